// File: rtl/prio_pkg.sv
// prio_pkg: shared FSM state type and wrap-around downward search used by the arbiter.
package prio_pkg;
    typedef enum logic {IDLE, GRANT} state_t;

    // Returns {found, index}: first set bit of vec[n-1:0] scanning start, start-1, ..., 0, n-1, ...
    function automatic logic [5:0] find_down(input logic [31:0] vec, input logic [4:0] start, input int n);
        logic [5:0] r;
        int idx;
        r = '0;
        for (int k = 31; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(start) >= k) ? int'(start) - k : int'(start) + n - k;
                if (vec[idx]) r = {1'b1, idx[4:0]};
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/prio_arbiter_rr_if.sv
// prio_arbiter_rr_if: request/grant bundle between N requesters and the arbiter.
interface prio_arbiter_rr_if #(parameter int N = 8);
    localparam int W = $clog2(N);
    logic [N-1:0] req;
    logic         mode;
    logic         done;
    logic [N-1:0] grant;
    logic [W-1:0] y;
    logic         v;
    modport master (output req, mode, done, input grant, y, v);
    modport slave  (input req, mode, done, output grant, y, v);
endinterface

// File: rtl/prio_find_n.sv
// prio_find_n: combinational search for the first set bit downward from i_start with wrap.
module prio_find_n
    import prio_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);
    logic [31:0] w_vec;
    logic [5:0]  w_res;
    always_comb begin
        w_vec = '0;
        w_vec[N-1:0] = i_vec;
    end
    assign w_res   = find_down(w_vec, 5'(i_start), N);
    assign o_found = w_res[5];
    assign o_idx   = W'(w_res[4:0]);
endmodule

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered N-way arbiter, fixed or round-robin priority, grant held until release.
module prio_arbiter_rr
    import prio_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input logic              clk,
    input logic              rst,
    prio_arbiter_rr_if.slave bus
);
    state_t       r_state, w_state;
    logic [N-1:0] r_grant, w_grant;
    logic [W-1:0] r_y, w_y, r_ptr, w_ptr, w_start, w_idx;
    logic         r_v, w_v, r_mode, w_mode, w_found, w_rel;

    assign w_start = bus.mode ? r_ptr : W'(N - 1);
    assign w_rel   = bus.done || !bus.req[r_y];

    prio_find_n #(.N(N)) u_find (
        .i_vec   (bus.req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_y     <= '0;
            r_v     <= 1'b0;
            r_ptr   <= W'(N - 1);
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_y     <= w_y;
            r_v     <= w_v;
            r_ptr   <= w_ptr;
            r_mode  <= w_mode;
        end
    end

    // r_mode remembers the mode a grant was won under, so a mode flip mid-grant cannot steer ptr
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_y     = r_y;
        w_v     = r_v;
        w_ptr   = r_ptr;
        w_mode  = r_mode;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_state = GRANT;
                w_grant = N'(1) << w_idx;
                w_y     = w_idx;
                w_v     = 1'b1;
                w_mode  = bus.mode;
            end
        end else if (w_rel) begin
            w_state = IDLE;
            w_grant = '0;
            w_y     = '0;
            w_v     = 1'b0;
            if (r_mode) w_ptr = (r_y == '0) ? W'(N - 1) : r_y - 1'b1;
        end
    end

    assign bus.grant = r_grant;
    assign bus.y     = r_y;
    assign bus.v     = r_v;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
    a_valid:  assert property (@(posedge clk) disable iff (rst) r_v == |r_grant);
    a_match:  assert property (@(posedge clk) disable iff (rst) !r_v || r_grant[r_y]);
    a_range:  assert property (@(posedge clk) disable iff (rst) 32'(r_y) < N);
endmodule
